// File: rtl/gpr_file_sb.sv
// rtl/gpr_file_sb.sv - dual-writeback register file with per-register scoreboard
//
// Purpose: general-purpose register file. Issue marks a destination pending
// (busy); writeback port 0 (ALU/CSR) and port 1 (load return) store data and
// clear busy. Register 0 is hardwired to zero and is never busy. A sticky
// err flag records protocol violations: same-index dual writeback and
// issue to a register that is still busy (WAW).
//
// Optional feature: define GPR_FILE_BYPASS_EN to forward in-flight writeback
// data to the read ports in the same cycle (wb1 wins over wb0). The
// forwarded write also clears rd_busy for that port.
//
// Ports:
//   clk, rstn             clock, synchronous active-low reset
//   rd_idx   [NRD*AW]     read indices, port k at [k*AW +: AW]
//   rd_data  [NRD*XLEN]   read data, port k at [k*XLEN +: XLEN]
//   rd_busy  [NRD]        scoreboard bit of each read index
//   iss_valid, iss_idx    mark destination pending
//   wb0_valid/idx/data    ALU writeback
//   wb1_valid/idx/data    load writeback
//   busy_vec [NREG]       registered scoreboard, bit 0 always 0
//   err                   sticky protocol error, cleared only by reset
module gpr_file_sb #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NRD*AW-1:0]   rd_idx,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_idx,
    input  logic                wb0_valid,
    input  logic [AW-1:0]       wb0_idx,
    input  logic [XLEN-1:0]     wb0_data,
    input  logic                wb1_valid,
    input  logic [AW-1:0]       wb1_idx,
    input  logic [XLEN-1:0]     wb1_data,
    output logic [NREG-1:0]     busy_vec,
    output logic                err
);

    logic [XLEN-1:0] r_gpr [NREG];
    logic [NREG-1:0] r_busy;
    logic            r_err;

    logic            w_wb0_hit;
    logic            w_wb1_hit;
    logic            w_iss_hit;
    logic            w_same_wb;
    logic            w_waw;
    logic [NREG-1:0] w_busy_nxt;

    // Index 0 traffic is dropped entirely, so it never writes, sets busy or errs.
    assign w_wb0_hit = wb0_valid && (wb0_idx != '0);
    assign w_wb1_hit = wb1_valid && (wb1_idx != '0);
    assign w_iss_hit = iss_valid && (iss_idx != '0);

    assign w_same_wb = w_wb0_hit && w_wb1_hit && (wb0_idx == wb1_idx);

    // A busy destination is only a WAW hazard if no writeback retires it this cycle.
    assign w_waw = w_iss_hit && r_busy[iss_idx]
                   && !(w_wb0_hit && (wb0_idx == iss_idx))
                   && !(w_wb1_hit && (wb1_idx == iss_idx));

    // Clears are applied before the set so a same-cycle issue wins the race.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wb0_hit) w_busy_nxt[wb0_idx] = 1'b0;
        if (w_wb1_hit) w_busy_nxt[wb1_idx] = 1'b0;
        if (w_iss_hit) w_busy_nxt[iss_idx] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) r_gpr[i] <= '0;
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            // wb1 is checked first so load data wins a same-index collision.
            for (int i = 1; i < NREG; i++) begin
                if (w_wb1_hit && (wb1_idx == AW'(i)))
                    r_gpr[i] <= wb1_data;
                else if (w_wb0_hit && (wb0_idx == AW'(i)))
                    r_gpr[i] <= wb0_data;
            end
            r_busy <= w_busy_nxt;
            if (w_same_wb || w_waw) r_err <= 1'b1;
        end
    end

    assign busy_vec = r_busy;
    assign err      = r_err;

    genvar k;
    for (k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] w_idx;
        assign w_idx = rd_idx[k*AW +: AW];
`ifdef GPR_FILE_BYPASS_EN
        logic w_fwd1;
        logic w_fwd0;
        assign w_fwd1 = w_wb1_hit && (wb1_idx == w_idx);
        assign w_fwd0 = w_wb0_hit && (wb0_idx == w_idx);
        assign rd_data[k*XLEN +: XLEN] = w_fwd1 ? wb1_data :
                                         w_fwd0 ? wb0_data : r_gpr[w_idx];
        assign rd_busy[k] = r_busy[w_idx] && !w_fwd1 && !w_fwd0;
`else
        assign rd_data[k*XLEN +: XLEN] = r_gpr[w_idx];
        assign rd_busy[k] = r_busy[w_idx];
`endif
    end

endmodule

// File: tb/tb_gpr_file_sb.sv
// tb/tb_gpr_file_sb.sv - scoreboard testbench for gpr_file_sb
module tb_gpr_file_sb;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rstn;
    logic [NRD*AW-1:0]   rd_idx;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                iss_valid;
    logic [AW-1:0]       iss_idx;
    logic                wb0_valid;
    logic [AW-1:0]       wb0_idx;
    logic [XLEN-1:0]     wb0_data;
    logic                wb1_valid;
    logic [AW-1:0]       wb1_idx;
    logic [XLEN-1:0]     wb1_data;
    logic [NREG-1:0]     busy_vec;
    logic                err;

    gpr_file_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
        .clk(clk), .rstn(rstn),
        .rd_idx(rd_idx), .rd_data(rd_data), .rd_busy(rd_busy),
        .iss_valid(iss_valid), .iss_idx(iss_idx),
        .wb0_valid(wb0_valid), .wb0_idx(wb0_idx), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_idx(wb1_idx), .wb1_data(wb1_data),
        .busy_vec(busy_vec), .err(err)
    );

    always #5 clk = ~clk;

    // kind: 0 rd_data[port], 1 rd_busy[port], 2 busy_vec, 3 err
    typedef struct {
        string       name;
        int          kind;
        int          port;
        logic [63:0] exp;
    } chk_t;

    chk_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Monitor: every cycle the DUT outputs are sampled at the falling edge and
    // compared against whatever the stimulus queued for that cycle.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            chk_t        c;
            logic [63:0] act;
            c = q.pop_front();
            case (c.kind)
                0:       act = rd_data[c.port*XLEN +: XLEN];
                1:       act = {63'd0, rd_busy[c.port]};
                2:       act = {32'd0, busy_vec};
                default: act = {63'd0, err};
            endcase
            n_tests++;
            if (act !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, act, c.exp);
            end
        end
    end

    task automatic expect_v(input string n, input int kind, input int port, input logic [63:0] v);
        chk_t c;
        c.name = n; c.kind = kind; c.port = port; c.exp = v;
        q.push_back(c);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        iss_valid = 1'b0;
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
    endtask

    task automatic rd(input int p, input int idx);
        logic [AW-1:0] v;
        v = idx[AW-1:0];
        rd_idx[p*AW +: AW] = v;
    endtask

    task automatic iss(input int idx);
        iss_valid = 1'b1; iss_idx = idx[AW-1:0];
    endtask

    task automatic wb0(input int idx, input logic [63:0] d);
        wb0_valid = 1'b1; wb0_idx = idx[AW-1:0]; wb0_data = d;
    endtask

    task automatic wb1(input int idx, input logic [63:0] d);
        wb1_valid = 1'b1; wb1_idx = idx[AW-1:0]; wb1_data = d;
    endtask

    initial begin
        rstn = 1'b0; rd_idx = '0;
        iss_valid = 1'b0; iss_idx = '0;
        wb0_valid = 1'b0; wb0_idx = '0; wb0_data = '0;
        wb1_valid = 1'b0; wb1_idx = '0; wb1_data = '0;

        // Reset held two edges with random traffic that must be ignored
        for (int r = 0; r < 2; r++) begin
            if (r > 0) cyc();
            wb0(int'($urandom_range(1, 31)), {$urandom, $urandom});
            wb1(int'($urandom_range(1, 31)), {$urandom, $urandom});
            iss(int'($urandom_range(1, 31)));
        end
        cyc();
        rstn = 1'b1;
        expect_v("reset_busy_vec", 2, 0, 64'd0);
        expect_v("reset_err", 3, 0, 64'd0);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) cyc();
            rd(0, 2*i); rd(1, 2*i + 1);
            expect_v($sformatf("reset_rd_x%0d", 2*i), 0, 0, 64'd0);
            expect_v($sformatf("reset_rd_x%0d", 2*i + 1), 0, 1, 64'd0);
        end

        // Basic write/read
        cyc(); iss(5);
        cyc(); expect_v("basic_busy_set", 2, 0, 64'h20);
        wb0(5, 64'h1234);
        cyc(); expect_v("basic_busy_clr", 2, 0, 64'd0);
        rd(1, 5); expect_v("basic_rd_x5", 0, 1, 64'h1234);
        wb0(0, 64'hFFFF);
        cyc(); rd(0, 0);
        expect_v("x0_rd", 0, 0, 64'd0);
        expect_v("x0_busy", 1, 0, 64'd0);
        expect_v("x0_err", 3, 0, 64'd0);

        // Load overlap
        cyc(); iss(7);
        cyc(); expect_v("ld_busy_set", 2, 0, 64'h80);
        cyc(); cyc();
        wb1(7, 64'hDEAD); wb0(8, 64'hBEEF);
        cyc(); rd(0, 7); rd(1, 8);
        expect_v("ld_rd_x7", 0, 0, 64'hDEAD);
        expect_v("ld_rd_x8", 0, 1, 64'hBEEF);
        expect_v("ld_busy_clr", 2, 0, 64'd0);
        expect_v("ld_err", 3, 0, 64'd0);

        // Issue/writeback race
        cyc(); iss(4);
        cyc(); wb0(4, 64'h55); iss(4);
        cyc(); rd(0, 4);
        expect_v("race_busy_vec", 2, 0, 64'h10);
        expect_v("race_rd_busy", 1, 0, 64'd1);
        expect_v("race_err", 3, 0, 64'd0);
        expect_v("race_rd_x4", 0, 0, 64'h55);
        wb0(4, 64'h56);
        cyc(); expect_v("race_cleanup", 2, 0, 64'd0);

        // Bypass: read x6 while wb1 writes it
        wb0(6, 64'h11);
        cyc(); iss(6);
        cyc();
        cyc(); wb1(6, 64'hAA); rd(0, 6);
`ifdef GPR_FILE_BYPASS_EN
        expect_v("byp_rd_data", 0, 0, 64'hAA);
        expect_v("byp_rd_busy", 1, 0, 64'd0);
`else
        expect_v("nobyp_rd_data", 0, 0, 64'h11);
        expect_v("nobyp_rd_busy", 1, 0, 64'd1);
`endif
        cyc();
        expect_v("byp_after_rd", 0, 0, 64'hAA);
        expect_v("byp_after_busy", 1, 0, 64'd0);
        expect_v("byp_err", 3, 0, 64'd0);

        // Same-index dual writeback
        wb0(9, 64'd1); wb1(9, 64'd2);
        cyc(); rd(1, 9);
        expect_v("dual_rd_x9", 0, 1, 64'd2);
        expect_v("dual_err", 3, 0, 64'd1);
        expect_v("dual_busy", 2, 0, 64'd0);
        cyc(); cyc(); cyc();
        expect_v("dual_err_sticky", 3, 0, 64'd1);

        // Reset clears err
        rstn = 1'b0;
        cyc(); rstn = 1'b1;
        expect_v("rst_err_clr", 3, 0, 64'd0);
        rd(1, 9); expect_v("rst_rd_x9", 0, 1, 64'd0);

        // Index 0 issue twice and write: no error
        iss(0);
        cyc(); iss(0); wb0(0, 64'h1);
        cyc(); expect_v("x0_iss_err", 3, 0, 64'd0);
        expect_v("x0_iss_busy", 2, 0, 64'd0);

        // WAW: issue x3 twice
        iss(3);
        cyc(); expect_v("waw_first_err", 3, 0, 64'd0);
        iss(3);
        cyc(); expect_v("waw_err", 3, 0, 64'd1);
        expect_v("waw_busy", 2, 0, 64'h8);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gpr_file_sb.md
# gpr_file_sb

Parametrised general-purpose register file with two writeback ports, a per-register scoreboard and optional write-to-read bypass. It sits between decode/issue (reads operands, marks destinations pending) and the two writeback paths: ALU/CSR results (port 0) and late-returning load data (port 1). It replaces the single-write-port register file. Stalling decisions move to issue logic, which reads `rd_busy`/`busy_vec` instead of gating writes with instruction/load valid strobes.

## Interface
Parameters:
- `XLEN`, default 64: register width.
- `NREG`, default 32: register count. Power of two, 2..64.
- `NRD`, default 2: read ports, 1..4.
- `AW`, default `$clog2(NREG)`: index width. Derived; do not override.

Ports:
- `clk`, in, 1: clock.
- `rstn`, in, 1: reset, synchronous, active-low.
- `rd_idx`, in, NRD*AW: read indices, flattened; port k uses bits [k*AW +: AW].
- `rd_data`, out, NRD*XLEN: read data, port k uses bits [k*XLEN +: XLEN].
- `rd_busy`, out, NRD: scoreboard bit for each read index.
- `iss_valid`, in, 1: issue of an instruction that writes `iss_idx`.
- `iss_idx`, in, AW: destination register to mark pending.
- `wb0_valid`, `wb0_idx` (AW), `wb0_data` (XLEN), in: ALU writeback.
- `wb1_valid`, `wb1_idx` (AW), `wb1_data` (XLEN), in: load writeback.
- `busy_vec`, out, NREG: full scoreboard; bit 0 is always 0.
- `err`, out, 1: sticky protocol-error flag.

## Operation
- Storage: `gpr[NREG]` of XLEN bits and `busy[NREG]`. Reset clears all registers, `busy` and `err` to 0. Reset overrides every other input in the same cycle.
- Register 0 is hardwired:
  - reads return 0 and `rd_busy` is 0;
  - writes and issues to index 0 are dropped and never raise `err`.
- Write: each `wbN_valid` with a nonzero index writes `wbN_data` at the edge and clears `busy[idx]`.
  - Writing a register that is not busy is legal: data is written, busy stays 0.
- Same-index dual write (`wb0_valid & wb1_valid`, equal nonzero indices):
  - wb1 data is stored;
  - `busy` is cleared;
  - `err` sets.
- Issue: `iss_valid` with a nonzero `iss_idx` sets `busy[iss_idx]` at the edge.
  - Issue beats a same-cycle clearing writeback to the same index, so `busy` ends at 1.
- Issue to an index with `busy=1` sets `err` (WAW not permitted), unless a writeback to that index clears it in the same cycle. Busy remains 1 either way.
- `err` stays set until reset.
- Reads are combinational from `rd_idx`, for all NRD ports independently.

## Timing
- Read latency is 0 cycles (combinational).
- A write is visible on `rd_data` the cycle after the edge that captures it, or in the same cycle with bypass enabled.
- `busy_vec` and `err` are register outputs and update one edge after the causing inputs.
- `rd_busy` timing:
  - without bypass, it is `busy[rd_idx]` as registered;
  - with bypass, it also shows 0 when a valid writeback to that index is present this cycle, and no issue logic is involved.
- No handshake back-pressure: writeback and issue are accepted every cycle.

## Configuration
- Macro: `GPR_FILE_BYPASS_EN`.
- Defined:
  - `rd_data[k]` returns the in-flight writeback data when `rd_idx[k]` matches a valid nonzero writeback index, with wb1 priority over wb0;
  - `rd_busy[k]` is cleared by that writeback.
  - This adds a mux path from `wbN_data` to `rd_data`.
- Undefined: `rd_data` and `rd_busy` reflect stored state only, and writeback and issue stage must be separated by a stall cycle.

## Test plan
- Reset: hold `rstn=0` for 2 cycles with random writes applied. Then all reads = 0, `busy_vec=0`, `err=0`.
- Basic write/read: issue x5, then a wb0 write of x5=0x1234 next cycle.
  - `busy_vec[5]` is 1 for one cycle, then 0.
  - Reading port 1 with x5 gives 0x1234.
  - An x0 write of 0xFFFF still reads 0.
- Load overlap: issue x7; 3 cycles later wb1 writes x7=0xDEAD while wb0 writes x8=0xBEEF.
  - Both are stored, `busy[7]` clears, `err=0`.
- Conflicts:
  - wb0 and wb1 writing x9 with 1/2 in the same cycle stores x9=2 and gives `err=1`, which persists until reset.
  - Issuing x3 twice with no writeback gives `err=1`.
- Issue/writeback race: x4 busy; wb0 writes x4=0x55 in the same cycle as a new issue to x4.
  - Gives `busy[4]=1`, `err=0`, x4=0x55.
- Bypass (macro on): reading x6 during the cycle wb1 writes x6=0xAA gives `rd_data=0xAA`, `rd_busy=0`. With the macro off, the same read returns the old value and the old busy bit.
